ram2_arbiter: RTL and testbench
===============================

Name: ram2_arbiter

Overview:
- Shares the single RAM2 controller between two requesters: instruction fetch (IF, read-only) and the MEM stage (read/write).
- Sits between the IF/MEM stages and the RAM2 controller.
- Produces the pipeline `hold`, drops fetch results on `flush`, and exports an 8-bit status byte and the last-fetched PC for the debug LED mux.
- One transaction is outstanding at a time. MEM has fixed priority over IF.

Parameters:
- ADDR_W, 16, address width of both requesters and RAM2.
- DATA_W, 16, data width.
- TIMEOUT_CYCLES, 255, busy cycles without ram2_work_done before timeout_err sets.
- CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-low
- if_need  input  1  IF read request, level; held until if_done
- if_addr  input  ADDR_W  IF address, stable while if_need
- if_pc  input  16  PC of the fetch, stable while if_need
- if_done  output  1  one-cycle completion pulse to IF
- if_res  output  DATA_W  fetched word, valid with if_done, held afterwards
- mem_need  input  1  MEM request, level; held until mem_done
- mem_wr  input  1  1 = write, 0 = read
- mem_addr  input  ADDR_W  MEM address
- mem_data  input  DATA_W  MEM write data
- mem_done  output  1  one-cycle completion pulse to MEM
- mem_res  output  DATA_W  read data, valid with mem_done
- flush  input  1  pipeline flush; discards the in-flight IF result
- ram2_need_to_work  output  1  request to the RAM2 controller
- ram2_wr  output  1  op to the RAM2 controller
- ram2_addr  output  ADDR_W  address to the RAM2 controller
- ram2_data  output  DATA_W  write data to the RAM2 controller
- ram2_work_done  input  1  RAM2 completion, sampled on clk
- ram2_work_res  input  DATA_W  RAM2 read data, valid with ram2_work_done
- hold  output  1  stall request to the pipeline
- timeout_err  output  1  sticky watchdog flag
- ram2_status  output  8  debug status byte
- done_pc  output  16  if_pc of the last IF fetch actually delivered

Behaviour:
- **Reset.** rst low asynchronously forces:
  - state = IDLE;
  - ram2_need_to_work, ram2_wr, if_done, mem_done, timeout_err, drop = 0;
  - ram2_addr, ram2_data, if_res, mem_res, done_pc = 0;
  - watchdog count = 0.
  A reset mid-transaction abandons it; the RAM2 controller must tolerate ram2_need_to_work dropping.
- **States:** IDLE, BUSY_IF, BUSY_MEM, RESP. An `owner` register (0 = IF, 1 = MEM) records who was granted.
- **IDLE.**
  - mem_need=1: register mem_wr/mem_addr/mem_data onto ram2_*, set ram2_need_to_work=1, owner=MEM, go to BUSY_MEM.
  - Else if_need=1: ram2_wr=0, ram2_addr=if_addr, capture if_pc internally, owner=IF, drop=0, go to BUSY_IF.
  - If both are set, MEM wins; IF waits.
- **BUSY_x.**
  - ram2_* are held stable and the watchdog increments each cycle.
  - When ram2_work_done=1 is sampled: ram2_need_to_work<=0, latch ram2_work_res into the owner's *_res (only if that owner is not dropped), clear the watchdog, go to RESP.
- **RESP (exactly one cycle).**
  - owner=MEM: mem_done=1.
  - owner=IF: if_done=1 and done_pc<=captured pc, unless drop=1 or flush=1 in this cycle.
  - Next state is IDLE. Re-arbitration samples requests on the edge after RESP, so minimum turnaround is done + 1 cycle. Requesters must update need on the edge following their done.
- **Flush.**
  - flush=1 in BUSY_IF sets drop=1; the RAM2 access still completes, but neither if_done nor if_res/done_pc is updated.
  - flush has no effect on MEM transactions, nor in IDLE.
- **hold** (combinational) = mem_need & ~mem_done.
- **Watchdog.** When count reaches TIMEOUT_CYCLES, timeout_err<=1 and stays set until reset. The transaction is not aborted and the count saturates.
- **ram2_status bit map:**
  - [7:6] state (IDLE=0, BUSY_IF=1, BUSY_MEM=2, RESP=3);
  - [5] owner; [4] drop; [3] timeout_err; [2] mem_need; [1] if_need; [0] hold.
- ram2_work_done outside BUSY_* is ignored.
- Latency: with a RAM2 controller that responds k cycles after request, done is asserted k+2 cycles after the request is sampled in IDLE.

Decomposition:
- Shared defines header holds:
  - state encodings and ram2_status bit positions;
  - the existing RegValue/MemValue/RegAddr width macros.
- One natural sub-module: ram2_watchdog (saturating counter, clear, sticky flag; parameters TIMEOUT_CYCLES, CNT_W).

Test Plan:
1. **MEM read.** Reset; mem_need=1, mem_wr=0, mem_addr=0x1234; RAM2 model returns 0xBEEF after 2 cycles. Required:
   - ram2_addr=0x1234;
   - mem_done pulses once with mem_res=0xBEEF;
   - hold=1 until the mem_done cycle;
   - if_done stays 0.
2. **Simultaneous requests.** if_need (addr 0x0040, pc 0x0040) and mem_need (write 0x8000 ← 0x00AA) asserted together. Required:
   - MEM is served first (ram2_wr=1, ram2_data=0x00AA);
   - then IF; if_done follows mem_done by at least 2 cycles;
   - done_pc=0x0040.
3. **Flush mid-fetch.** IF fetch at pc 0x0100; flush=1 for one cycle during BUSY_IF. Required:
   - the RAM2 access completes;
   - if_done never pulses;
   - done_pc keeps its previous value;
   - ram2_status[4]=1 during the tail of BUSY_IF and in RESP.
4. **Watchdog.** TIMEOUT_CYCLES=8; RAM2 never asserts done. Required:
   - timeout_err=1 after 8 busy cycles and stays set;
   - ram2_need_to_work stays 1;
   - releasing done later completes normally and timeout_err remains 1.
5. **Reset mid-transaction.** rst low during BUSY_MEM. Required, immediately (asynchronous):
   - ram2_need_to_work=0, hold reflects mem_need only, ram2_status[7:6]=0;
   - after release, a new IF request is served from IDLE.
6. **Back-to-back IF.** IF requests at 0x0000 then 0x0001, with need re-asserted on the edge after if_done. Required:
   - both complete in order;
   - the second grant starts exactly 1 cycle after RESP.

Source files
------------

// File: rtl/ram2_arbiter_pkg.sv
// Shared definitions for the RAM2 arbiter: state encoding, status byte layout and
// the legacy register/memory width constants.
package ram2_arbiter_pkg;

   localparam int unsigned RegValueW = 16;
   localparam int unsigned MemValueW = 16;
   localparam int unsigned MemAddrW  = 16;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StBusyIf  = 2'd1,
      StBusyMem = 2'd2,
      StResp    = 2'd3
   } ram2_state_e;

   localparam int unsigned StatStateLsb = 6;
   localparam int unsigned StatOwner    = 5;
   localparam int unsigned StatDrop     = 4;
   localparam int unsigned StatTimeout  = 3;
   localparam int unsigned StatMemNeed  = 2;
   localparam int unsigned StatIfNeed   = 1;
   localparam int unsigned StatHold     = 0;

   function automatic logic [7:0] pack_status(input ram2_state_e st, input logic owner,
                                              input logic drop, input logic tmo,
                                              input logic mem_need, input logic if_need,
                                              input logic hold);
      logic [7:0] s;
      s                       = '0;
      s[StatStateLsb +: 2]    = st;
      s[StatOwner]            = owner;
      s[StatDrop]             = drop;
      s[StatTimeout]          = tmo;
      s[StatMemNeed]          = mem_need;
      s[StatIfNeed]           = if_need;
      s[StatHold]             = hold;
      return s;
   endfunction

endpackage

// File: rtl/ram2_arbiter_watchdog.sv
// Busy-cycle watchdog: saturating counter with synchronous clear and a sticky
// error flag that sets when the count reaches TIMEOUT_CYCLES.
module ram2_arbiter_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic inc_i,
   input  logic clr_i,
   output logic err_o
);

   localparam logic [CNT_W-1:0] Limit = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != Limit)) begin
         cnt_d = cnt_q + 1'b1;
      end
      err_d = err_q | (inc_i & (cnt_d == Limit));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err_o = err_q;

endmodule

// File: rtl/ram2_arbiter.sv
// Shares one RAM2 controller between instruction fetch and the MEM stage, one
// transaction at a time, MEM first. Also produces hold, flush drop and debug status.
module ram2_arbiter
   import ram2_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W         = MemAddrW,
   parameter int unsigned DATA_W         = MemValueW,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 if_need,
   input  logic [ADDR_W-1:0]    if_addr,
   input  logic [RegValueW-1:0] if_pc,
   output logic                 if_done,
   output logic [DATA_W-1:0]    if_res,
   input  logic                 mem_need,
   input  logic                 mem_wr,
   input  logic [ADDR_W-1:0]    mem_addr,
   input  logic [DATA_W-1:0]    mem_data,
   output logic                 mem_done,
   output logic [DATA_W-1:0]    mem_res,
   input  logic                 flush,
   output logic                 ram2_need_to_work,
   output logic                 ram2_wr,
   output logic [ADDR_W-1:0]    ram2_addr,
   output logic [DATA_W-1:0]    ram2_data,
   input  logic                 ram2_work_done,
   input  logic [DATA_W-1:0]    ram2_work_res,
   output logic                 hold,
   output logic                 timeout_err,
   output logic [7:0]           ram2_status,
   output logic [RegValueW-1:0] done_pc
);

   ram2_state_e          state_q, state_d;
   logic                 owner_q, owner_d;
   logic                 drop_q, drop_d;
   logic                 need_q, need_d;
   logic                 wr_q, wr_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]    data_q, data_d;
   logic [DATA_W-1:0]    if_res_q, if_res_d;
   logic [DATA_W-1:0]    mem_res_q, mem_res_d;
   logic                 if_done_q, if_done_d;
   logic                 mem_done_q, mem_done_d;
   logic [RegValueW-1:0] pc_q, pc_d;
   logic [RegValueW-1:0] done_pc_q, done_pc_d;
   logic                 busy, wd_inc, wd_clr;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      drop_d     = drop_q;
      need_d     = need_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      data_d     = data_q;
      if_res_d   = if_res_q;
      mem_res_d  = mem_res_q;
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
      pc_d       = pc_q;
      done_pc_d  = done_pc_q;
      unique case (state_q)
         StIdle: begin
            if (mem_need) begin
               need_d  = 1'b1;
               wr_d    = mem_wr;
               addr_d  = mem_addr;
               data_d  = mem_data;
               owner_d = 1'b1;
               state_d = StBusyMem;
            end else if (if_need) begin
               need_d  = 1'b1;
               wr_d    = 1'b0;
               addr_d  = if_addr;
               pc_d    = if_pc;
               owner_d = 1'b0;
               drop_d  = 1'b0;
               state_d = StBusyIf;
            end
         end
         StBusyIf: begin
            // A flush coinciding with completion still discards the fetch.
            drop_d = drop_q | flush;
            if (ram2_work_done) begin
               need_d  = 1'b0;
               state_d = StResp;
               if (!drop_d) begin
                  if_res_d  = ram2_work_res;
                  if_done_d = 1'b1;
               end
            end
         end
         StBusyMem: begin
            if (ram2_work_done) begin
               need_d     = 1'b0;
               mem_res_d  = ram2_work_res;
               mem_done_d = 1'b1;
               state_d    = StResp;
            end
         end
         StResp: begin
            state_d = StIdle;
            if (!owner_q && !drop_q && !flush) begin
               done_pc_d = pc_q;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         owner_q    <= 1'b0;
         drop_q     <= 1'b0;
         need_q     <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         if_res_q   <= '0;
         mem_res_q  <= '0;
         if_done_q  <= 1'b0;
         mem_done_q <= 1'b0;
         pc_q       <= '0;
         done_pc_q  <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         drop_q     <= drop_d;
         need_q     <= need_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         if_res_q   <= if_res_d;
         mem_res_q  <= mem_res_d;
         if_done_q  <= if_done_d;
         mem_done_q <= mem_done_d;
         pc_q       <= pc_d;
         done_pc_q  <= done_pc_d;
      end
   end

   assign busy   = (state_q == StBusyIf) || (state_q == StBusyMem);
   assign wd_inc = busy & ~ram2_work_done;
   assign wd_clr = busy & ram2_work_done;

   ram2_arbiter_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_watchdog (
      .clk_i  (clk),
      .rst_ni (rst),
      .inc_i  (wd_inc),
      .clr_i  (wd_clr),
      .err_o  (timeout_err)
   );

   // A flush arriving in the RESP cycle itself must still suppress the pulse.
   assign if_done           = if_done_q & ~flush;
   assign if_res            = if_res_q;
   assign mem_done          = mem_done_q;
   assign mem_res           = mem_res_q;
   assign ram2_need_to_work = need_q;
   assign ram2_wr           = wr_q;
   assign ram2_addr         = addr_q;
   assign ram2_data         = data_q;
   assign done_pc           = done_pc_q;
   assign hold              = mem_need & ~mem_done_q;
   assign ram2_status       = pack_status(state_q, owner_q, drop_q, timeout_err, mem_need,
                                          if_need, hold);

endmodule

// File: tb/tb_ram2_arbiter.sv
// Scoreboard bench for ram2_arbiter: directed requests, a behavioural RAM2 model and
// a monitor that checks every completion pulse against queued expectations.
module tb_ram2_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_need, mem_need, mem_wr, flush;
   logic [15:0] if_addr, if_pc, mem_addr, mem_data;
   logic        if_done, mem_done;
   logic [15:0] if_res, mem_res;
   logic        ram2_need_to_work, ram2_wr, ram2_work_done;
   logic [15:0] ram2_addr, ram2_data, ram2_work_res;
   logic        hold, timeout_err;
   logic [7:0]  ram2_status;
   logic [15:0] done_pc;

   typedef struct {logic chk; logic [15:0] data;} mexp_t;
   typedef struct {logic [15:0] data; logic [15:0] pc;} iexp_t;
   mexp_t mem_q[$];
   iexp_t if_q[$];

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          ram_lat = 2;
   logic        ram_stall = 1'b0;
   logic [15:0] mem_arr [logic [15:0]];
   int          mcnt;
   logic        pc_pend = 1'b0;
   logic [15:0] pc_exp;
   mexp_t       me;
   iexp_t       ie;

   ram2_arbiter #(
      .ADDR_W         (16),
      .DATA_W         (16),
      .TIMEOUT_CYCLES (8),
      .CNT_W          (8)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .if_need           (if_need),
      .if_addr           (if_addr),
      .if_pc             (if_pc),
      .if_done           (if_done),
      .if_res            (if_res),
      .mem_need          (mem_need),
      .mem_wr            (mem_wr),
      .mem_addr          (mem_addr),
      .mem_data          (mem_data),
      .mem_done          (mem_done),
      .mem_res           (mem_res),
      .flush             (flush),
      .ram2_need_to_work (ram2_need_to_work),
      .ram2_wr           (ram2_wr),
      .ram2_addr         (ram2_addr),
      .ram2_data         (ram2_data),
      .ram2_work_done    (ram2_work_done),
      .ram2_work_res     (ram2_work_res),
      .hold              (hold),
      .timeout_err       (timeout_err),
      .ram2_status       (ram2_status),
      .done_pc           (done_pc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic bad(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got timeout/unexpected event, want expected event", nm);
   endtask

   task automatic wait_state(input logic [1:0] st, input string nm, output int at);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((ram2_status[7:6] != st) && (n < 60));
      at = cyc;
      if (ram2_status[7:6] != st) bad(nm);
   endtask

   task automatic wait_done(input logic is_mem, input string nm, output int at);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(is_mem ? mem_done : if_done) && (n < 60));
      at = cyc;
      if (!(is_mem ? mem_done : if_done)) bad(nm);
   endtask

   // RAM2 model: answers ram_lat cycles after it first sees the request.
   initial begin
      ram2_work_done = 1'b0;
      ram2_work_res  = 16'h0;
      mcnt           = 0;
      forever begin
         @(posedge clk);
         #1;
         ram2_work_done = 1'b0;
         if (!ram2_need_to_work) begin
            mcnt = 0;
         end else if (!ram_stall) begin
            mcnt++;
            if (mcnt == ram_lat) begin
               mcnt           = 0;
               ram2_work_done = 1'b1;
               if (ram2_wr) begin
                  mem_arr[ram2_addr] = ram2_data;
                  ram2_work_res      = 16'h0;
               end else begin
                  ram2_work_res = mem_arr.exists(ram2_addr) ? mem_arr[ram2_addr] : 16'h0;
               end
            end
         end
      end
   end

   // Monitor: pops and compares on every completion pulse.
   always @(negedge clk) begin
      if (pc_pend) begin
         chk("done_pc", 32'(done_pc), 32'(pc_exp));
         pc_pend = 1'b0;
      end
      if (mem_done) begin
         if (mem_q.size() == 0) begin
            bad("mem_done_unexpected");
         end else begin
            me = mem_q.pop_front();
            if (me.chk) chk("mem_res", 32'(mem_res), 32'(me.data));
         end
      end
      if (if_done) begin
         if (if_q.size() == 0) begin
            bad("if_done_unexpected");
         end else begin
            ie = if_q.pop_front();
            chk("if_res", 32'(if_res), 32'(ie.data));
            pc_exp  = ie.pc;
            pc_pend = 1'b1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL sim_timeout: got no finish, want finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      int t0, t1;
      logic seen_resp;
      rst = 1'b1; if_need = 1'b0; mem_need = 1'b0; mem_wr = 1'b0; flush = 1'b0;
      if_addr = '0; if_pc = '0; mem_addr = '0; mem_data = '0;
      mem_arr[16'h1234] = 16'hBEEF;
      mem_arr[16'h0040] = 16'hCAFE;
      mem_arr[16'h0100] = 16'h3333;
      mem_arr[16'h0200] = 16'h5A5A;
      mem_arr[16'h0300] = 16'h7777;
      mem_arr[16'h0000] = 16'h0A0A;
      mem_arr[16'h0001] = 16'h0B0B;
      #2 rst = 1'b0;
      #1;
      chk("rst_need", 32'(ram2_need_to_work), 0);
      chk("rst_status", 32'(ram2_status), 0);
      chk("rst_outs", {if_done, mem_done, timeout_err, ram2_wr}, 0);
      chk("rst_data", {if_res, mem_res}, 0);
      chk("rst_done_pc", 32'(done_pc), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // 1: MEM read
      @(posedge clk); #1;
      mem_need = 1'b1; mem_wr = 1'b0; mem_addr = 16'h1234;
      mem_q.push_back('{chk: 1'b1, data: 16'hBEEF});
      wait_state(2'd2, "t1_grant", t0);
      chk("t1_ram2_addr", 32'(ram2_addr), 32'h1234);
      chk("t1_ram2_ctl", {ram2_need_to_work, ram2_wr}, 2'b10);
      chk("t1_hold_busy", 32'(hold), 1);
      wait_done(1'b1, "t1_done", t1);
      chk("t1_hold_done", 32'(hold), 0);
      @(posedge clk); #1 mem_need = 1'b0;
      @(negedge clk);
      chk("t1_hold_idle", 32'(hold), 0);

      // 2: simultaneous requests, MEM wins
      @(posedge clk); #1;
      if_need = 1'b1; if_addr = 16'h0040; if_pc = 16'h0040;
      mem_need = 1'b1; mem_wr = 1'b1; mem_addr = 16'h8000; mem_data = 16'h00AA;
      mem_q.push_back('{chk: 1'b0, data: 16'h0});
      if_q.push_back('{data: 16'hCAFE, pc: 16'h0040});
      wait_state(2'd2, "t2_mem_grant", t0);
      chk("t2_mem_op", {ram2_wr, ram2_addr, ram2_data}, {1'b1, 16'h8000, 16'h00AA});
      wait_done(1'b1, "t2_mem_done", t0);
      @(posedge clk); #1 mem_need = 1'b0; mem_wr = 1'b0;
      wait_state(2'd1, "t2_if_grant", t1);
      chk("t2_if_op", {ram2_wr, ram2_addr}, {1'b0, 16'h0040});
      wait_done(1'b0, "t2_if_done", t1);
      chk("t2_gap_ge2", 32'((t1 - t0) >= 2), 1);
      @(posedge clk); #1 if_need = 1'b0;
      chk("t2_written", 32'(mem_arr[16'h8000]), 32'h00AA);

      // 3: flush mid-fetch
      ram_lat = 4;
      @(posedge clk); #1;
      if_need = 1'b1; if_addr = 16'h0100; if_pc = 16'h0100;
      wait_state(2'd1, "t3_grant", t0);
      @(posedge clk); #1 flush = 1'b1; if_need = 1'b0;
      @(posedge clk); #1 flush = 1'b0;
      seen_resp = 1'b0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (ram2_status[7:6] == 2'd0) break;
         if (ram2_status[7:6] == 2'd3) seen_resp = 1'b1;
         chk("t3_drop_bit", 32'(ram2_status[4]), 1);
      end
      chk("t3_completed", 32'(seen_resp), 1);
      chk("t3_done_pc_kept", 32'(done_pc), 32'h0040);
      chk("t3_if_res_kept", 32'(if_res), 32'hCAFE);
      ram_lat = 2;

      // 4: watchdog
      ram_stall = 1'b1;
      @(posedge clk); #1;
      mem_need = 1'b1; mem_wr = 1'b0; mem_addr = 16'h0200;
      mem_q.push_back('{chk: 1'b1, data: 16'h5A5A});
      wait_state(2'd2, "t4_grant", t0);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 7) chk("t4_err_pre", 32'(timeout_err), 0);
         if (k == 8) chk("t4_err_set", 32'(timeout_err), 1);
      end
      chk("t4_err_sticky", {timeout_err, ram2_need_to_work, ram2_status[3]}, 3'b111);
      @(posedge clk); #1 ram_stall = 1'b0;
      wait_done(1'b1, "t4_done", t1);
      @(posedge clk); #1 mem_need = 1'b0;
      @(negedge clk);
      chk("t4_err_after", 32'(timeout_err), 1);

      // 5: reset mid-transaction
      ram_stall = 1'b1;
      @(posedge clk); #1;
      mem_need = 1'b1; mem_wr = 1'b1; mem_addr = 16'h0300; mem_data = 16'h1234;
      wait_state(2'd2, "t5_grant", t0);
      @(posedge clk); #1 rst = 1'b0;
      #1;
      chk("t5_need_off", 32'(ram2_need_to_work), 0);
      chk("t5_hold", 32'(hold), 1);
      chk("t5_state", 32'(ram2_status[7:6]), 0);
      chk("t5_err_clr", 32'(timeout_err), 0);
      mem_need = 1'b0; mem_wr = 1'b0;
      #1 chk("t5_hold_off", 32'(hold), 0);
      ram_stall = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      if_need = 1'b1; if_addr = 16'h0300; if_pc = 16'h0300;
      if_q.push_back('{data: 16'h7777, pc: 16'h0300});
      wait_state(2'd1, "t5_if_grant", t0);
      chk("t5_if_addr", 32'(ram2_addr), 32'h0300);
      wait_done(1'b0, "t5_if_done", t1);
      @(posedge clk); #1 if_need = 1'b0;

      // 6: back-to-back IF
      @(posedge clk); #1;
      if_need = 1'b1; if_addr = 16'h0000; if_pc = 16'h0000;
      if_q.push_back('{data: 16'h0A0A, pc: 16'h0000});
      wait_done(1'b0, "t6_first", t0);
      @(posedge clk); #1 if_addr = 16'h0001; if_pc = 16'h0001;
      if_q.push_back('{data: 16'h0B0B, pc: 16'h0001});
      wait_state(2'd1, "t6_regrant", t1);
      chk("t6_turnaround", 32'(t1 - t0), 2);
      chk("t6_addr", 32'(ram2_addr), 32'h0001);
      wait_done(1'b0, "t6_second", t1);
      @(posedge clk); #1 if_need = 1'b0;

      repeat (3) @(negedge clk);
      chk("sb_mem_empty", 32'(mem_q.size()), 0);
      chk("sb_if_empty", 32'(if_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
